mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/rv32i_types.sv | 19 +
 rtl/mem_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/rv32i_types.sv
// Shared types for the memory-side arbiter: FSM states, requester sides
// and the line/address widths used on every DFP port.
package rv32i_types;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } arb_side_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one cacheline adapter between the I-cache and
// the D-cache; one transaction in flight, with an IDLE cycle between grants.
module mem_arbiter
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] i_dfp_addr,
    input  logic              i_dfp_read,
    output logic [LINE_W-1:0] i_dfp_rdata,
    output logic              i_dfp_resp,

    input  logic [ADDR_W-1:0] d_dfp_addr,
    input  logic              d_dfp_read,
    input  logic              d_dfp_write,
    input  logic [LINE_W-1:0] d_dfp_wdata,
    output logic [LINE_W-1:0] d_dfp_rdata,
    output logic              d_dfp_resp,

    output logic [ADDR_W-1:0] m_dfp_addr,
    output logic              m_dfp_read,
    output logic              m_dfp_write,
    output logic [LINE_W-1:0] m_dfp_wdata,
    input  logic [LINE_W-1:0] m_dfp_rdata,
    input  logic              m_dfp_resp,

    output logic [31:0]       i_grant_cnt,
    output logic [31:0]       d_grant_cnt
);

    arb_state_t state;
    arb_side_t  last_grant;
    logic       latched_write;

    logic i_req;
    logic d_req;
    logic pick_d;
    logic pick_i;

    assign i_req  = i_dfp_read;
    assign d_req  = d_dfp_read | d_dfp_write;
    // On a tie the side that did not win last time takes the grant.
    assign pick_d = d_req && (!i_req || (last_grant == ARB_I));
    assign pick_i = i_req && !pick_d;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values and the grant decision sees a consistent snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            last_grant    <= ARB_I;
            latched_write <= 1'b0;
            m_dfp_addr    <= '0;
            m_dfp_wdata   <= '0;
            i_grant_cnt   <= '0;
            d_grant_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state         <= SERVE_D;
                        last_grant    <= ARB_D;
                        m_dfp_addr    <= d_dfp_addr;
                        m_dfp_wdata   <= d_dfp_wdata;
                        latched_write <= d_dfp_write;
                        d_grant_cnt   <= d_grant_cnt + 32'd1;
                    end else if (pick_i) begin
                        state       <= SERVE_I;
                        last_grant  <= ARB_I;
                        m_dfp_addr  <= i_dfp_addr;
                        i_grant_cnt <= i_grant_cnt + 32'd1;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (m_dfp_resp) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_dfp_read  = (state == SERVE_I) || ((state == SERVE_D) && !latched_write);
    assign m_dfp_write = (state == SERVE_D) && latched_write;

    // The response path is purely combinational so no cycles are added.
    assign i_dfp_resp  = (state == SERVE_I) && m_dfp_resp;
    assign d_dfp_resp  = (state == SERVE_D) && m_dfp_resp;
    assign i_dfp_rdata = m_dfp_rdata;
    assign d_dfp_rdata = m_dfp_rdata;

endmodule
